// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control fields from ID through EX, MEM and WB,
// detects load-use hazards (stall plus bubble) and generates EX operand
// forwarding selects for a 5-stage CPU.
//
// Build option: define CTRL_PIPELINE_FWD_EN to enable operand forwarding. When
// it is undefined the forwarding selects are tied to 00, and every RAW
// dependency on an instruction in EX or MEM stalls ID instead.
module ctrl_pipeline #(
  parameter int AW = 5,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   Control_i,
  input  logic [AW-1:0] RSaddr_i,
  input  logic [AW-1:0] RTaddr_i,
  input  logic [AW-1:0] RDaddr_i,
  input  logic          Flush_i,
  output logic          EX_RegDst_o,
  output logic          EX_ALUSrc_o,
  output logic [1:0]    EX_ALUOp_o,
  output logic          MEM_MemWrite_o,
  output logic          MEM_MemRead_o,
  output logic          WB_MemtoReg_o,
  output logic          WB_RegWrite_o,
  output logic [AW-1:0] WB_RDaddr_o,
  output logic          Stall_o,
  output logic [1:0]    ForwardA_o,
  output logic [1:0]    ForwardB_o
);

  // Bit positions inside the packed control word.
  localparam int B_REG_DST   = 7;
  localparam int B_ALU_SRC   = 6;
  localparam int B_ALU_OP_HI = 5;
  localparam int B_ALU_OP_LO = 4;
  localparam int B_MEM_WRITE = 3;
  localparam int B_MEM_READ  = 2;
  localparam int B_MEM_TO_REG = 1;
  localparam int B_REG_WRITE = 0;

  // ID/EX stage register.
  logic [7:0]    idex_ctrl;
  logic [AW-1:0] idex_rs;
  logic [AW-1:0] idex_rt;
  logic [AW-1:0] idex_rd;

  // EX/MEM stage register.
  logic          exmem_mem_write;
  logic          exmem_mem_read;
  logic          exmem_mem_to_reg;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_dst;

  // MEM/WB stage register.
  logic          memwb_mem_to_reg;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_dst;

  logic [7:0]    ctrl_live;
  logic [AW-1:0] idex_dst;
  logic          load_use;
  logic          hazard;

  // Keep only the live control bits; anything above CW reads as zero.
  always_comb begin
    // NOTE: assign a default before any partial write so no latch is inferred.
    ctrl_live = '0;
    ctrl_live[CW-1:0] = Control_i[CW-1:0];
  end

  assign idex_dst = idex_ctrl[B_REG_DST] ? idex_rd : idex_rt;

  // Load in EX whose target is read by the instruction in ID; register 0 is exempt.
  always_comb begin
    load_use = idex_ctrl[B_MEM_READ] && (idex_rt != '0) &&
               ((idex_rt == RSaddr_i) || (idex_rt == RTaddr_i));
  end

`ifdef CTRL_PIPELINE_FWD_EN
  logic unused_bits;
  assign unused_bits = ^Control_i[31:CW];

  assign hazard = load_use;

  // Operand source selects: the younger result in EX/MEM wins over MEM/WB.
  always_comb begin
    ForwardA_o = 2'b00;
    ForwardB_o = 2'b00;
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rs))
      ForwardA_o = 2'b10;
    else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rs))
      ForwardA_o = 2'b01;
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rt))
      ForwardB_o = 2'b10;
    else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rt))
      ForwardB_o = 2'b01;
  end
`else
  logic unused_bits;
  logic raw_ex;
  logic raw_mem;
  assign unused_bits = ^{Control_i[31:CW], idex_rs};

  // Without forwarding, any pending write in EX or MEM to a source of ID must drain.
  always_comb begin
    raw_ex  = idex_ctrl[B_REG_WRITE] && (idex_dst != '0) &&
              ((idex_dst == RSaddr_i) || (idex_dst == RTaddr_i));
    raw_mem = exmem_reg_write && (exmem_dst != '0) &&
              ((exmem_dst == RSaddr_i) || (exmem_dst == RTaddr_i));
  end

  assign hazard     = load_use | raw_ex | raw_mem;
  assign ForwardA_o = 2'b00;
  assign ForwardB_o = 2'b00;
`endif

  // A taken branch overrides the stall so the PC can move to the target.
  assign Stall_o = hazard & ~Flush_i;

  // ID/EX: take the decoded instruction, or a bubble on hazard or flush.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // register samples the pre-edge values of the others.
    if (rst_i || hazard || Flush_i) begin
      idex_ctrl <= '0;
      idex_rs   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
    end else begin
      idex_ctrl <= ctrl_live;
      idex_rs   <= RSaddr_i;
      idex_rt   <= RTaddr_i;
      idex_rd   <= RDaddr_i;
    end
  end

  // EX/MEM: always advances; the destination is resolved as it enters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_mem_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_dst        <= '0;
    end else begin
      exmem_mem_write  <= idex_ctrl[B_MEM_WRITE];
      exmem_mem_read   <= idex_ctrl[B_MEM_READ];
      exmem_mem_to_reg <= idex_ctrl[B_MEM_TO_REG];
      exmem_reg_write  <= idex_ctrl[B_REG_WRITE];
      exmem_dst        <= idex_dst;
    end
  end

  // MEM/WB: always advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      memwb_mem_to_reg <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_dst        <= '0;
    end else begin
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_reg_write  <= exmem_reg_write;
      memwb_dst        <= exmem_dst;
    end
  end

  assign EX_RegDst_o    = idex_ctrl[B_REG_DST];
  assign EX_ALUSrc_o    = idex_ctrl[B_ALU_SRC];
  assign EX_ALUOp_o     = idex_ctrl[B_ALU_OP_HI:B_ALU_OP_LO];
  assign MEM_MemWrite_o = exmem_mem_write;
  assign MEM_MemRead_o  = exmem_mem_read;
  assign WB_MemtoReg_o  = memwb_mem_to_reg;
  assign WB_RegWrite_o  = memwb_reg_write;
  assign WB_RDaddr_o    = memwb_dst;

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

- Carries the packed 32-bit control word produced by the instruction decoder through the ID/EX, EX/MEM and MEM/WB stages, handing each stage its own control fields.
- Tracks source and destination register numbers so it can detect load-use hazards (stall plus bubble) and generate ALU operand forwarding selects.
- Honours a branch flush by squashing the instruction leaving ID.
- Sits between the decoder and the datapath pipeline registers of the 5-stage CPU.

## Interface
Parameters:
- AW, 5, register address width
- CW, 8, number of live control bits in the packed word (bits [CW-1:0]; upper bits ignored)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- Control_i  in  32  packed control word: [7] RegDst, [6] ALUSrc, [5:4] ALUOp, [3] MemWrite, [2] MemRead, [1] MemtoReg, [0] RegWrite; [31:8] ignored
- RSaddr_i  in  AW  rs of instruction in ID
- RTaddr_i  in  AW  rt of instruction in ID
- RDaddr_i  in  AW  rd of instruction in ID
- Flush_i  in  1  branch taken; squash the instruction in ID
- EX_RegDst_o, EX_ALUSrc_o  out  1 each  EX-stage controls
- EX_ALUOp_o  out  2  EX-stage ALU op
- MEM_MemWrite_o, MEM_MemRead_o  out  1 each  MEM-stage controls
- WB_MemtoReg_o, WB_RegWrite_o  out  1 each  WB-stage controls
- WB_RDaddr_o  out  AW  write-back destination register
- Stall_o  out  1  hold PC and IF/ID this cycle
- ForwardA_o, ForwardB_o  out  2 each  EX operand source: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result

## Operation
**Stage registers**
- ID/EX holds the 8 control bits plus rs, rt and rd.
- EX/MEM holds MemWrite, MemRead, MemtoReg, RegWrite and the destination register. The destination is resolved on entry as RegDst ? rd : rt.
- MEM/WB holds MemtoReg, RegWrite and the destination register.
- EX/MEM → MEM/WB always advances. The pipeline is never frozen behind ID.

**Load-use hazard**
- hazard = IDEX.MemRead & (IDEX.rt != 0) & (IDEX.rt == RSaddr_i | IDEX.rt == RTaddr_i).

**ID/EX load**
- ID/EX loads an all-zero control word (bubble) when hazard or Flush_i is asserted.
- Otherwise it loads Control_i[7:0] and the three addresses.

**Stall**
- Stall_o = hazard & ~Flush_i.
- Flush wins so the PC can still take the branch target.

**Forwarding**
- Forwarding is combinational from the stage registers. For operand A (rs):
  - 10 if EXMEM.RegWrite & EXMEM.dst != 0 & EXMEM.dst == IDEX.rs;
  - else 01 if MEMWB.RegWrite & MEMWB.dst != 0 & MEMWB.dst == IDEX.rs;
  - else 00.
- Operand B uses the same rule with IDEX.rt.
- EX/MEM has priority over MEM/WB when both match.
- Register 0 is never forwarded and never causes a stall.

**Register file**
- The register file is write-first. A MEM/WB-to-ID dependency needs no action here.

## Timing
- Reset (rst_i high at a rising edge) clears all three stage registers. The same applies when rst_i is asserted mid-operation; in-flight instructions are discarded.
- Resulting output values after reset:
  - all stage outputs 0;
  - WB_RDaddr_o = 0;
  - ForwardA/B_o = 00;
  - Stall_o = 0.
- Latency from Control_i sampled at edge N:
  - EX outputs valid after edge N;
  - MEM outputs valid after edge N+1;
  - WB outputs valid after edge N+2.
- Stall_o, ForwardA_o and ForwardB_o are combinational. They are valid in the same cycle as their inputs, with no registered delay.
- A load-use stall lasts exactly one cycle. The bubble enters EX at the next edge, after which IDEX.MemRead = 0 and hazard deasserts.
- If Flush_i and hazard are both high: bubble inserted, Stall_o = 0.
- Flush_i and rst_i together: reset wins.

## Configuration
- CTRL_PIPELINE_FWD_EN defined:
  - forwarding logic as described above;
  - stall on load-use only.
- CTRL_PIPELINE_FWD_EN undefined:
  - ForwardA_o and ForwardB_o are tied to 00.
  - hazard additionally covers every RAW dependency on IDEX.dst and on EXMEM.dst: RegWrite set, dst != 0, and dst == RSaddr_i or RTaddr_i.
  - IDEX.dst is computed combinationally as RegDst ? rd : rt.
  - A back-to-back dependency therefore stalls 2 cycles.
  - Flush priority is unchanged.

## Test plan
- **Reset:** rst_i high 2 cycles with Control_i=0x57 and addresses nonzero → every output 0 and Stall_o=0; first edge after release loads 0x57 → EX_ALUSrc_o=1, EX_ALUOp_o=01.
- **Pass-through:** Control_i=0x81 with rd=3, then 0x58, 0x41, 0x70 → WB_RegWrite_o=1 and WB_RDaddr_o=3 two edges after EX shows RegDst=1; MEM_MemWrite_o=1 exactly one cycle for 0x58; EX_ALUOp_o=11 for 0x70.
- **Load-use:** lw (0x57, rt=5) then ID rs=5 → Stall_o=1 for one cycle; next cycle all EX and MEM outputs of the bubble are 0, Stall_o=0; (FWD_EN) ForwardA_o=01 when the dependent reaches EX.
- **Forwarding (FWD_EN):** add rd=4; add rs=4 → ForwardA_o=10. With one independent instruction between → 01. Using rd=0 → 00. When both EX/MEM and MEM/WB hold dst=4 → 10.
- **Flush vs stall:** load-use condition with Flush_i=1 in the same cycle → Stall_o=0; next EX controls all 0.
- **No FWD_EN:** add rd=4 followed by sub rs=4 → Stall_o=1 for 2 consecutive cycles; ForwardA_o stays 00 throughout; sub reaches EX after the add reaches WB.
